// File: rtl/fp_add_normalize_round.sv
// Add/subtract, normalize, round-to-nearest-even and pack stage of the FP adder.
// Define NORM_LZC_EN to normalize in a single cycle with a leading-zero count.
module fp_add_normalize_round #(
    parameter logic [7:0]  EXP_MAX = 8'hFF,
    parameter logic [31:0] QNAN    = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic        signA,
    input  logic        signB,
    input  logic [23:0] alignedMantissaA,
    input  logic [23:0] alignedMantissaB,
    input  logic [7:0]  exponentIn,
    input  logic        guardBit,
    input  logic        roundBit,
    input  logic        stickyBit,
    input  logic        grsOwnerB,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADD   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [26:0] op_a_q, op_a_d;
    logic [26:0] op_b_q, op_b_d;
    logic        sign_q, sign_d;
    logic [23:0] mant_q, mant_d;
    logic        g_q, g_d;
    logic        r_q, r_d;
    logic        s_q, s_d;
    logic [7:0]  exp_q, exp_d;
    logic [31:0] result_q, result_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    logic [2:0]  grs_in;
    logic [31:0] special_result;
    logic        a_msb_zero, b_msb_zero;
    logic        a_frac_nz, b_frac_nz;
    logic [27:0] add_sum;
    logic        a_larger;
    logic [26:0] sub_diff;
    logic        round_inc;
    logic [24:0] round_sum;
    logic [23:0] round_mant;
    logic [8:0]  round_exp;
    logic        round_ovf;

    assign grs_in = {guardBit, roundBit, stickyBit};

    // Special operands: an msb-0 mantissa at the all-ones exponent is Inf (fraction 0) or NaN.
    assign a_msb_zero = ~alignedMantissaA[23];
    assign b_msb_zero = ~alignedMantissaB[23];
    assign a_frac_nz  = |alignedMantissaA[22:0];
    assign b_frac_nz  = |alignedMantissaB[22:0];

    always_comb begin
        special_result = {signA, EXP_MAX, 23'd0};
        if ((a_msb_zero && a_frac_nz) || (b_msb_zero && b_frac_nz)) begin
            special_result = QNAN;
        end else if (a_msb_zero && b_msb_zero && (signA != signB)) begin
            special_result = QNAN;
        end else if (a_msb_zero) begin
            special_result = {signA, EXP_MAX, 23'd0};
        end else if (b_msb_zero) begin
            special_result = {signB, EXP_MAX, 23'd0};
        end
    end

    assign add_sum  = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign a_larger = (op_a_q > op_b_q);
    assign sub_diff = a_larger ? (op_a_q - op_b_q) : (op_b_q - op_a_q);

    // Round to nearest, ties to even; a mantissa carry renormalizes to 1.0 with exponent + 1.
    assign round_inc  = g_q & (r_q | s_q | mant_q[0]);
    assign round_sum  = {1'b0, mant_q} + {24'd0, round_inc};
    assign round_mant = round_sum[24] ? 24'h800000 : round_sum[23:0];
    assign round_exp  = {1'b0, exp_q} + {8'd0, round_sum[24]};
    assign round_ovf  = (round_exp >= {1'b0, EXP_MAX});

`ifdef NORM_LZC_EN
    logic [25:0] norm_vec;
    logic [4:0]  lzc;
    logic [7:0]  exp_room;
    logic [7:0]  shift_amt;
    logic [25:0] norm_shifted;

    assign norm_vec = {mant_q, g_q, r_q};

    always_comb begin
        lzc = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (norm_vec[i]) begin
                lzc = 5'(25 - i);
            end
        end
    end

    // The exponent may not drop below 1, so the shift is clamped to exp - 1.
    assign exp_room     = (exp_q > 8'd1) ? (exp_q - 8'd1) : 8'd0;
    assign shift_amt    = ({3'd0, lzc} < exp_room) ? {3'd0, lzc} : exp_room;
    assign norm_shifted = norm_vec << shift_amt;
`endif

    always_comb begin
        state_d     = state_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sign_d      = sign_q;
        mant_d      = mant_q;
        g_d         = g_q;
        r_d         = r_q;
        s_d         = s_q;
        exp_d       = exp_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        case (state_q)
            S_IDLE: begin
                if (inValid && inReady) begin
                    sign_a_d    = signA;
                    sign_b_d    = signB;
                    op_a_d      = {alignedMantissaA, grsOwnerB ? 3'b000 : grs_in};
                    op_b_d      = {alignedMantissaB, grsOwnerB ? grs_in : 3'b000};
                    exp_d       = exponentIn;
                    overflow_d  = 1'b0;
                    underflow_d = 1'b0;
                    if (exponentIn == EXP_MAX) begin
                        result_d = special_result;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end

            S_ADD: begin
                if (sign_a_q == sign_b_q) begin
                    sign_d  = sign_a_q;
                    state_d = S_NORM;
                    if (add_sum[27]) begin
                        mant_d = add_sum[27:4];
                        g_d    = add_sum[3];
                        r_d    = add_sum[2];
                        s_d    = add_sum[1] | add_sum[0];
                        exp_d  = exp_q + 8'd1;
                    end else begin
                        mant_d = add_sum[26:3];
                        g_d    = add_sum[2];
                        r_d    = add_sum[1];
                        s_d    = add_sum[0];
                    end
                end else if (op_a_q == op_b_q) begin
                    result_d = 32'd0;
                    state_d  = S_DONE;
                end else begin
                    sign_d  = a_larger ? sign_a_q : sign_b_q;
                    mant_d  = sub_diff[26:3];
                    g_d     = sub_diff[2];
                    r_d     = sub_diff[1];
                    s_d     = sub_diff[0];
                    state_d = S_NORM;
                end
            end

            S_NORM: begin
`ifdef NORM_LZC_EN
                if (mant_q[23]) begin
                    state_d = S_ROUND;
                end else begin
                    mant_d = norm_shifted[25:2];
                    g_d    = norm_shifted[1];
                    r_d    = norm_shifted[0];
                    exp_d  = exp_q - shift_amt;
                    if (norm_shifted[25]) begin
                        state_d = S_ROUND;
                    end else begin
                        result_d    = {sign_q, 31'd0};
                        underflow_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
`else
                if (mant_q[23]) begin
                    state_d = S_ROUND;
                end else if (exp_q > 8'd1) begin
                    mant_d = {mant_q[22:0], g_q};
                    g_d    = r_q;
                    r_d    = 1'b0;
                    exp_d  = exp_q - 8'd1;
                end else begin
                    result_d    = {sign_q, 31'd0};
                    underflow_d = 1'b1;
                    state_d     = S_DONE;
                end
`endif
            end

            S_ROUND: begin
                mant_d     = round_mant;
                exp_d      = round_exp[7:0];
                overflow_d = round_ovf;
                result_d   = round_ovf ? {sign_q, EXP_MAX, 23'd0}
                                       : {sign_q, round_exp[7:0], round_mant[22:0]};
                state_d    = S_DONE;
            end

            S_DONE: begin
                if (outReady) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            op_a_q      <= 27'd0;
            op_b_q      <= 27'd0;
            sign_q      <= 1'b0;
            mant_q      <= 24'd0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            exp_q       <= 8'd0;
            result_q    <= 32'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sign_q      <= sign_d;
            mant_q      <= mant_d;
            g_q         <= g_d;
            r_q         <= r_d;
            s_q         <= s_d;
            exp_q       <= exp_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign inReady   = (state_q == S_IDLE) && !reset;
    assign outValid  = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
